// File: rtl/offset_hold_aggregate_core.sv
// Event shift register (last three accepted samples) plus a periodic sliding-window sum
// of the input stream over the last NUM_BUCKETS evaluation periods.
module offset_hold_aggregate_core #(
  parameter int unsigned WIDTH         = 32,
  parameter int unsigned PERIOD_CYCLES = 10000,
  parameter int unsigned NUM_BUCKETS   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             a_valid,
  input  logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] result_0,
  output logic [WIDTH-1:0] result_1,
  output logic [WIDTH-1:0] result_2,
  output logic [WIDTH-1:0] result_3,
  output logic             event_valid,
  output logic             period_valid
);

  localparam int unsigned CntW = (PERIOD_CYCLES > 1) ? $clog2(PERIOD_CYCLES) : 1;
  localparam int unsigned PtrW = (NUM_BUCKETS > 1) ? $clog2(NUM_BUCKETS) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(PERIOD_CYCLES - 1);
  localparam logic [PtrW-1:0] PtrLast = PtrW'(NUM_BUCKETS - 1);

  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] total_q, total_d;
  logic [WIDTH-1:0] r0_q, r0_d, r1_q, r1_d, r2_q, r2_d;
  logic [WIDTH-1:0] slot_q [NUM_BUCKETS];
  logic [WIDTH-1:0] slot_d [NUM_BUCKETS];
  logic             ev_q, ev_d, pv_q, pv_d;

  logic             accept, tick;
  logic [WIDTH-1:0] closing;

  always_comb begin
    accept   = en & a_valid;
    tick     = en & (cnt_q == CntLast);
    // An event on the tick cycle still belongs to the bucket being closed.
    closing  = acc_q + (accept ? a : '0);

    cnt_d    = cnt_q;
    wr_ptr_d = wr_ptr_q;
    acc_d    = acc_q;
    total_d  = total_q;
    r0_d     = r0_q;
    r1_d     = r1_q;
    r2_d     = r2_q;
    slot_d   = slot_q;
    ev_d     = accept;
    pv_d     = tick;

    if (en) begin
      cnt_d = tick ? '0 : cnt_q + CntW'(1);
    end

    if (accept) begin
      r0_d = a;
      r1_d = r0_q;
      r2_d = r1_q;
    end

    if (tick) begin
      slot_d[wr_ptr_q] = closing;
      wr_ptr_d         = (wr_ptr_q == PtrLast) ? '0 : wr_ptr_q + PtrW'(1);
      acc_d            = '0;
      total_d          = total_q + closing - slot_q[wr_ptr_q];
    end else if (accept) begin
      acc_d = closing;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q    <= '0;
      wr_ptr_q <= '0;
      acc_q    <= '0;
      total_q  <= '0;
      r0_q     <= '0;
      r1_q     <= '0;
      r2_q     <= '0;
      ev_q     <= 1'b0;
      pv_q     <= 1'b0;
      for (int i = 0; i < int'(NUM_BUCKETS); i++) begin
        slot_q[i] <= '0;
      end
    end else begin
      cnt_q    <= cnt_d;
      wr_ptr_q <= wr_ptr_d;
      acc_q    <= acc_d;
      total_q  <= total_d;
      r0_q     <= r0_d;
      r1_q     <= r1_d;
      r2_q     <= r2_d;
      ev_q     <= ev_d;
      pv_q     <= pv_d;
      for (int i = 0; i < int'(NUM_BUCKETS); i++) begin
        slot_q[i] <= slot_d[i];
      end
    end
  end

  assign result_0     = r0_q;
  assign result_1     = r1_q;
  assign result_2     = r2_q;
  assign result_3     = total_q;
  assign event_valid  = ev_q;
  assign period_valid = pv_q;

endmodule
